mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS load/store unit with an Avalon-MM style master port
// Three-state FSM (IDLE/ACCESS/DONE); request fields are latched on start.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] load_result,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] rt_old_q, rt_old_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;
    logic [31:0] ea;

    assign ea = base + offset;

    function automatic logic op_ok(input logic [5:0] op, input logic [1:0] lo);
        case (op)
            OP_LB, OP_LBU, OP_LWL: op_ok = 1'b1;
            OP_LH, OP_LHU:         op_ok = ~lo[0];
            OP_LW, OP_SW:          op_ok = (lo == 2'b00);
            default:               op_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [5:0] op, input logic [1:0] k,
                                               input logic [31:0] rd, input logic [31:0] old);
        logic [7:0]  lane;
        logic [15:0] half;
        case (k)
            2'd0:    lane = rd[7:0];
            2'd1:    lane = rd[15:8];
            2'd2:    lane = rd[23:16];
            default: lane = rd[31:24];
        endcase
        half = k[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   load_value = {{24{lane[7]}}, lane};
            OP_LBU:  load_value = {24'h0, lane};
            OP_LH:   load_value = {{16{half[15]}}, half};
            OP_LHU:  load_value = {16'h0, half};
            OP_LW:   load_value = rd;
            // LWL: the addressed byte and those below it land in the top of rt
            OP_LWL: begin
                case (k)
                    2'd0:    load_value = {rd[7:0],  old[23:0]};
                    2'd1:    load_value = {rd[15:0], old[15:0]};
                    2'd2:    load_value = {rd[23:0], old[7:0]};
                    default: load_value = rd;
                endcase
            end
            default: load_value = 32'h0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 6'h0;
            ea_q     <= 32'h0;
            sdata_q  <= 32'h0;
            rt_old_q <= 32'h0;
            err_q    <= 1'b0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ea_q     <= ea_d;
            sdata_q  <= sdata_d;
            rt_old_q <= rt_old_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ea_d       = ea_q;
        sdata_d    = sdata_q;
        rt_old_d   = rt_old_q;
        err_d      = err_q;
        result_d   = result_q;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        error      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 32'h0;
        writedata  = 32'h0;
        byteenable = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = opcode;
                    ea_d     = ea;
                    sdata_d  = store_data;
                    rt_old_d = rt_old;
                    if (op_ok(opcode, ea[1:0])) begin
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                    end else begin
                        err_d    = 1'b1;
                        result_d = 32'h0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                address    = {ea_q[31:2], 2'b00};
                byteenable = 4'b1111;
                if (op_q == OP_SW) begin
                    write     = 1'b1;
                    writedata = sdata_q;
                end else begin
                    read = 1'b1;
                end
                if (!waitrequest) begin
                    result_d = load_value(op_q, ea_q[1:0], readdata, rt_old_q);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                error   = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign load_result = result_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [31:0] rt_old;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] load_result;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .base(base), .offset(offset), .store_data(store_data), .rt_old(rt_old),
        .busy(busy), .done(done), .error(error), .load_result(load_result),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request through one edge, then scramble the inputs so only latched values matter.
    task automatic issue(input logic [5:0] op, input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] sd, input logic [31:0] ro);
        opcode = op; base = b; offset = o; store_data = sd; rt_old = ro; start = 1'b1;
        tick();
        start = 1'b0; opcode = 6'h3F; base = ~b; offset = ~o; store_data = ~sd; rt_old = ~ro;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 6'h0; base = 32'h0; offset = 32'h0;
        store_data = 32'h0; rt_old = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
        #2;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_rw", {30'h0, read, write}, 32'h0);
        chk("rst_addr", address, 32'h0);
        chk("rst_be", {28'h0, byteenable}, 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_result", load_result, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // LB with wrapping address, no wait states
        readdata = 32'h80FF1234; waitrequest = 1'b0;
        issue(6'h20, 32'h00001000, 32'hFFFFFFFF, 32'h0, 32'h0);
        chk("lb_read", {31'h0, read}, 32'h1);
        chk("lb_write", {31'h0, write}, 32'h0);
        chk("lb_addr", address, 32'h00000FFC);
        chk("lb_be", {28'h0, byteenable}, 32'hF);
        chk("lb_done_early", {31'h0, done}, 32'h0);
        tick();
        chk("lb_done", {31'h0, done}, 32'h1);
        chk("lb_err", {31'h0, error}, 32'h0);
        chk("lb_read_off", {31'h0, read}, 32'h0);
        chk("lb_result", load_result, 32'hFFFFFF80);
        tick();
        chk("lb_idle_busy", {31'h0, busy}, 32'h0);
        chk("lb_hold_result", load_result, 32'hFFFFFF80);

        // LHU with three wait states; a start during busy must not queue
        readdata = 32'hBEEF0000; waitrequest = 1'b1;
        issue(6'h25, 32'h00002000, 32'h00000002, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("lhu_read_held", {31'h0, read}, 32'h1);
            chk("lhu_addr_stable", address, 32'h00002000);
            chk("lhu_no_done", {31'h0, done}, 32'h0);
            start = (i == 1);
            if (i == 1) opcode = 6'h23;
            if (i == 3) waitrequest = 1'b0;
            tick();
        end
        start = 1'b0;
        chk("lhu_done", {31'h0, done}, 32'h1);
        chk("lhu_result", load_result, 32'h0000BEEF);
        tick();
        chk("lhu_idle", {31'h0, busy}, 32'h0);
        tick();
        chk("lhu_no_queue", {31'h0, busy}, 32'h0);

        // SW
        issue(6'h2B, 32'h00003000, 32'h0, 32'hDEADBEEF, 32'h0);
        chk("sw_write", {31'h0, write}, 32'h1);
        chk("sw_read", {31'h0, read}, 32'h0);
        chk("sw_wdata", writedata, 32'hDEADBEEF);
        chk("sw_be", {28'h0, byteenable}, 32'hF);
        chk("sw_addr", address, 32'h00003000);
        tick();
        chk("sw_done", {31'h0, done}, 32'h1);
        chk("sw_err", {31'h0, error}, 32'h0);
        chk("sw_result", load_result, 32'h0);
        tick();

        // Misaligned LW, then an unsupported opcode: error with no bus access
        issue(6'h23, 32'h00003001, 32'h0, 32'h0, 32'h0);
        chk("lwmis_done", {31'h0, done}, 32'h1);
        chk("lwmis_err", {31'h0, error}, 32'h1);
        chk("lwmis_rw", {30'h0, read, write}, 32'h0);
        chk("lwmis_result", load_result, 32'h0);
        tick();
        issue(6'h08, 32'h00003000, 32'h0, 32'h0, 32'h0);
        chk("badop_done", {31'h0, done}, 32'h1);
        chk("badop_err", {31'h0, error}, 32'h1);
        chk("badop_rw", {30'h0, read, write}, 32'h0);
        tick();
        chk("badop_idle", {31'h0, busy}, 32'h0);

        // LWL merge with rt_old
        readdata = 32'hAABBCCDD;
        issue(6'h22, 32'h00004000, 32'h00000001, 32'h0, 32'h11223344);
        chk("lwl_read", {31'h0, read}, 32'h1);
        tick();
        chk("lwl_done", {31'h0, done}, 32'h1);
        chk("lwl_result", load_result, 32'hCCDD3344);
        tick();

        // LH sign extension from the upper halfword
        readdata = 32'h80015555;
        issue(6'h21, 32'h00006000, 32'h00000002, 32'h0, 32'h0);
        tick();
        chk("lh_result", load_result, 32'hFFFF8001);
        tick();

        // Reset in the middle of a stalled access
        waitrequest = 1'b1; readdata = 32'h12345678;
        issue(6'h23, 32'h00005000, 32'h0, 32'h0, 32'h0);
        chk("rstmid_read", {31'h0, read}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_read_drop", {31'h0, read}, 32'h0);
        chk("rstmid_busy", {31'h0, busy}, 32'h0);
        chk("rstmid_addr", address, 32'h0);
        tick();
        reset = 1'b0; waitrequest = 1'b0;
        tick();
        chk("rstmid_no_done1", {31'h0, done}, 32'h0);
        tick();
        chk("rstmid_no_done2", {31'h0, done}, 32'h0);
        issue(6'h23, 32'h00005000, 32'h0, 32'h0, 32'h0);
        chk("fresh_read", {31'h0, read}, 32'h1);
        tick();
        chk("fresh_done", {31'h0, done}, 32'h1);
        chk("fresh_result", load_result, 32'h12345678);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
